// File: rtl/prescaled_modulo_counter.sv
// Prescaled modulo counter: board-clock prescaler produces a step strobe that
// advances an up/down modulo counter with runtime period and limit, synchronous
// load, enable/pause, and registered tick/terminal pulses for digit chaining.
module prescaled_modulo_counter #(
   parameter int WIDTH     = 8,
   parameter int DIV_WIDTH = 30
) (
   input  logic                 clk_in,
   input  logic                 reset,
   input  logic [DIV_WIDTH-1:0] period,
   input  logic [WIDTH-1:0]     limit,
   input  logic                 enable,
   input  logic                 up_down,
   input  logic                 load,
   input  logic [WIDTH-1:0]     load_value,
   output logic [WIDTH-1:0]     out,
   output logic                 tick,
   output logic                 terminal
);

   localparam logic [DIV_WIDTH-1:0] DIV_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0]     CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH:0]       LIM_ONE = {{WIDTH{1'b0}}, 1'b1};

   logic [DIV_WIDTH-1:0] presc_q, presc_d;
   logic [WIDTH-1:0]     out_q, out_d;
   logic                 tick_q, tick_d;
   logic                 terminal_q, terminal_d;

   logic [DIV_WIDTH-1:0] eff_period_m1;
   logic [WIDTH:0]       eff_limit;
   logic [WIDTH:0]       eff_limit_m1;
   logic                 step;

   // Effective period/limit and the step strobe; the >= compare means a period
   // shrunk below the running prescaler steps immediately instead of wrapping.
   always_comb begin
      eff_period_m1 = (period == '0) ? '0 : (period - DIV_ONE);
      eff_limit     = (limit == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, limit};
      eff_limit_m1  = eff_limit - LIM_ONE;
      step          = enable && (presc_q >= eff_period_m1);
   end

   // Next-state: load beats step beats hold (reset is applied in the register).
   always_comb begin
      presc_d    = presc_q;
      out_d      = out_q;
      tick_d     = 1'b0;
      terminal_d = 1'b0;
      if (load) begin
         out_d   = load_value;
         presc_d = '0;
      end else if (step) begin
         presc_d = '0;
         tick_d  = 1'b1;
         if (up_down) begin
            if ({1'b0, out_q} >= eff_limit_m1) begin
               out_d      = '0;
               terminal_d = 1'b1;
            end else begin
               out_d = out_q + CNT_ONE;
            end
         end else begin
            if (out_q == '0) begin
               out_d      = eff_limit_m1[WIDTH-1:0];
               terminal_d = 1'b1;
            end else if ({1'b0, out_q} >= eff_limit) begin
               // Out-of-range value (loaded or limit lowered) snaps to the top.
               out_d = eff_limit_m1[WIDTH-1:0];
            end else begin
               out_d = out_q - CNT_ONE;
            end
         end
      end else if (enable) begin
         presc_d = presc_q + DIV_ONE;
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         presc_q    <= '0;
         out_q      <= '0;
         tick_q     <= 1'b0;
         terminal_q <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         out_q      <= out_d;
         tick_q     <= tick_d;
         terminal_q <= terminal_d;
      end
   end

   assign out      = out_q;
   assign tick     = tick_q;
   assign terminal = terminal_q;

endmodule

// File: tb/tb_prescaled_modulo_counter.sv
// Testbench: a behavioural reference model pushes the expected out/tick/terminal
// for every clock edge into a queue; the result is popped and compared after the edge.
module tb_prescaled_modulo_counter;

   localparam int WIDTH     = 8;
   localparam int DIV_WIDTH = 30;

   logic                 clk_in = 1'b0;
   logic                 reset;
   logic [DIV_WIDTH-1:0] period;
   logic [WIDTH-1:0]     limit;
   logic                 enable;
   logic                 up_down;
   logic                 load;
   logic [WIDTH-1:0]     load_value;
   logic [WIDTH-1:0]     out;
   logic                 tick;
   logic                 terminal;

   prescaled_modulo_counter #(.WIDTH(WIDTH), .DIV_WIDTH(DIV_WIDTH)) dut (
      .clk_in     (clk_in),
      .reset      (reset),
      .period     (period),
      .limit      (limit),
      .enable     (enable),
      .up_down    (up_down),
      .load       (load),
      .load_value (load_value),
      .out        (out),
      .tick       (tick),
      .terminal   (terminal)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      int o;
      int t;
      int tm;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   // reference model state
   int m_presc = 0;
   int m_out   = 0;
   int m_tick  = 0;
   int m_term  = 0;

   task automatic chk(input string tag, input int act, input int expv);
      n_chk++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, act, expv, $time);
   endtask

   // Advance the model with the current inputs, clock the DUT, compare.
   task automatic cyc();
      int   ep, el;
      exp_t e;
      ep = (period == 0) ? 1 : int'(period);
      el = (limit == 0) ? (1 << WIDTH) : int'(limit);
      m_tick = 0;
      m_term = 0;
      if (reset) begin
         m_presc = 0;
         m_out   = 0;
      end else if (load) begin
         m_out   = int'(load_value);
         m_presc = 0;
      end else if (enable) begin
         if (m_presc + 1 >= ep) begin
            m_presc = 0;
            m_tick  = 1;
            if (up_down) begin
               if (m_out + 1 >= el) begin m_out = 0; m_term = 1; end
               else m_out = m_out + 1;
            end else begin
               if (m_out == 0) begin m_out = el - 1; m_term = 1; end
               else if (m_out >= el) m_out = el - 1;
               else m_out = m_out - 1;
            end
         end else begin
            m_presc = m_presc + 1;
         end
      end
      e.o = m_out; e.t = m_tick; e.tm = m_term;
      exp_q.push_back(e);
      @(posedge clk_in);
      #1;
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 1, 0);
      end else begin
         e = exp_q.pop_front();
         chk("out", int'(out), e.o);
         chk("tick", int'(tick), e.t);
         chk("terminal", int'(terminal), e.tm);
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic do_load(input int v);
      load = 1'b1; load_value = WIDTH'(v);
      cyc();
      load = 1'b0;
   endtask

   initial begin
      int found;
      int hold_out;
      reset = 1'b1; period = 4; limit = 10; enable = 1'b1; up_down = 1'b1;
      load = 1'b0; load_value = '0;

      // reset state
      run(2);
      chk("rst_out", int'(out), 0);
      chk("rst_tick", int'(tick), 0);
      chk("rst_term", int'(terminal), 0);

      // basic up count: terminal on 9->0 exactly 40 cycles after release
      reset = 1'b0;
      found = -1;
      for (int i = 1; i <= 60 && found < 0; i++) begin
         cyc();
         if (terminal) found = i;
      end
      chk("up_term_cycle", found, 40);
      chk("up_wrap_out", int'(out), 0);

      // down count from 0 with period 1
      up_down = 1'b0; period = 1;
      do_load(0);
      cyc();
      chk("down_first", int'(out), 9);
      chk("down_first_term", int'(terminal), 1);
      run(11);

      // full range
      limit = 0; up_down = 1'b1;
      do_load(254);
      cyc(); chk("full_255", int'(out), 255);
      cyc(); chk("full_0", int'(out), 0); chk("full_0_term", int'(terminal), 1);
      cyc(); chk("full_1", int'(out), 1);
      up_down = 1'b0;
      do_load(0);
      cyc(); chk("full_dn_255", int'(out), 255); chk("full_dn_term", int'(terminal), 1);

      // pause mid-period
      limit = 10; up_down = 1'b1; period = 4;
      do_load(3);
      run(2);
      enable = 1'b0;
      hold_out = int'(out);
      for (int i = 0; i < 7; i++) begin
         cyc();
         chk("pause_out", int'(out), hold_out);
         chk("pause_tick", int'(tick), 0);
      end
      enable = 1'b1;
      run(1);   // presc resumes from 2 -> step at presc 3
      // period shrink below running prescaler
      period = 100;
      do_load(3);
      run(50);
      period = 2;
      cyc();
      chk("shrink_tick", int'(tick), 1);
      chk("shrink_out", int'(out), 4);

      // load priority over step, out-of-range value
      period = 1; limit = 10; up_down = 1'b1;
      do_load(200);
      chk("load_out", int'(out), 200);
      chk("load_tick", int'(tick), 0);
      cyc();
      chk("oor_up_out", int'(out), 0);
      chk("oor_up_term", int'(terminal), 1);
      // limit lowered below out, down step
      do_load(8);
      limit = 5; up_down = 1'b0;
      cyc();
      chk("limdn_out", int'(out), 4);
      chk("limdn_term", int'(terminal), 0);
      // reset beats load
      reset = 1'b1; load = 1'b1; load_value = 8'd77;
      cyc();
      chk("rst_load_out", int'(out), 0);
      reset = 1'b0; load = 1'b0;

      // reset mid-count, first step exactly period cycles later
      limit = 10; up_down = 1'b1; period = 5;
      do_load(7);
      run(3);
      reset = 1'b1;
      cyc();
      chk("midrst_out", int'(out), 0);
      chk("midrst_tick", int'(tick), 0);
      chk("midrst_term", int'(terminal), 0);
      reset = 1'b0;
      found = -1;
      for (int i = 1; i <= 20 && found < 0; i++) begin
         cyc();
         if (tick) found = i;
      end
      chk("midrst_first_step", found, 5);
      run(12);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
